alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Multi-cycle issuer for the datapath ALU: owns the Y operand register and the Z capture registers.
- Presents operands and the 5-bit ALU control code, waits the required settle time, then captures Zlow/Zhigh and pulses a register-file writeback.
- Sits between the control unit (start/opcode/operands) and the combinational ALU, which responds on the aluControl / BusMuxInY / BusMuxOut / Zlowout / Zhighout interface.

Parameters:
- ALU_WAIT, 1, cycles held in WAIT for single-cycle ops (minimum 1).
- MULDIV_WAIT, 4, cycles held in WAIT for opcodes 01110 (multiply) and 01111 (divide) (minimum 1).

Ports:
- clk  input  1  system clock, rising edge.
- clear  input  1  asynchronous active-high reset.
- start  input  1  request; sampled only in IDLE.
- opcode  input  5  ALU operation code, sampled with start.
- srcA  input  32  first operand, loaded into Y.
- srcB  input  32  second operand, driven on BusMuxOut.
- aluControl  output  5  ALU control code.
- BusMuxInY  output  32  Y register contents to ALU.
- BusMuxOut  output  32  second-operand latch to ALU.
- Zlowin  input  32  ALU low result.
- Zhighin  input  32  ALU high result.
- resultLo  output  32  captured Z low.
- resultHi  output  32  captured Z high.
- busy  output  1  high in every state except IDLE.
- writeEn  output  1  one-cycle writeback strobe.
- done  output  1  one-cycle completion strobe (valid and illegal ops).
- illegalOp  output  1  one-cycle strobe, concurrent with done, for an unsupported opcode.

Behaviour:
- Reset (clear=1, asynchronous): state=IDLE; every output 0, including Y, the operand latch, resultLo/Hi, aluControl, and all strobes. clear mid-operation aborts immediately with no writeback.
- Legal opcodes: 00011 through 01010, 01110, 01111, 10000, 10001. All other codes, including 00000, are illegal.
- States:
  - IDLE: aluControl=00000. On start=1 with a legal opcode: latch opcode; Y<=srcA; BusMuxOut latch<=srcB; go to LOADY. On start=1 with an illegal opcode: go to ERR.
  - LOADY: operands stable; aluControl held at 00000 for this full cycle. Go to PRESENT.
  - PRESENT: aluControl<=latched opcode (visible from this edge). Load the wait counter with ALU_WAIT, or MULDIV_WAIT for 01110/01111. Go to WAIT.
  - WAIT: decrement the counter each cycle; at zero go to CAPTURE. aluControl and operands are held constant throughout.
  - CAPTURE: resultLo<=Zlowin; resultHi<=Zhighin. Go to WRITE.
  - WRITE: writeEn=1, done=1, aluControl<=00000. Go to IDLE.
  - ERR: done=1, illegalOp=1. resultLo/Hi unchanged; aluControl never leaves 00000. Go to IDLE.
- The ALU evaluates only on a change of aluControl. Returning aluControl to 00000 between operations is mandatory, so back-to-back identical opcodes re-evaluate.
- Timing (start sampled at edge 0): aluControl valid after edge 2; done/writeEn high in the cycle after edge 3+W, where W is the applicable wait.
  - Add with ALU_WAIT=1: done after edge 4.
  - Next start accepted at edge 5.
- start while busy=1 is ignored and not queued. opcode/srcA/srcB changes after edge 0 have no effect on the running operation.
- resultLo/Hi hold their last captured value until the next CAPTURE. No arithmetic is performed in this block; Zhighin is captured verbatim.
- Y and the operand latch retain their values in IDLE after completion.
- done, writeEn and illegalOp never exceed one cycle; writeEn and illegalOp are never simultaneously high.

Test Plan:
- Add: clear then release; start with opcode=00011, srcA=5, srcB=7 -> BusMuxInY=5 and BusMuxOut=7 after edge 0; aluControl=00011 after edge 2; done=writeEn=1 after edge 4; resultLo=12, resultHi=0; aluControl=00000 again after edge 4.
- Sub with sign: opcode=00100, srcA=3, srcB=5 -> resultLo=0xFFFFFFFE, resultHi=0xFFFFFFFF, writeEn single pulse.
- Back-to-back identical ops: two opcode=00011 ops with start held high, second with srcA=1, srcB=1 -> second accepted at edge 5; aluControl drops to 00000 between the two issues; second resultLo=2.
- Divide latency: MULDIV_WAIT=4, opcode=01111, srcA=100, srcB=7 -> aluControl held at 01111 for 4 WAIT cycles; done after edge 7; resultLo=14.
- Illegal op: opcode=01011 -> done=illegalOp=1 after edge 1; writeEn=0; aluControl stays 00000; resultLo/Hi keep prior values (14).
- Abort/ignore: start pulsed during WAIT is ignored (no extra done); clear asserted mid-WAIT -> all outputs 0 before the next clk edge; no writeEn; a fresh start after release completes normally.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Multi-cycle ALU issuer: owns the Y operand and Z capture registers, presents the
// control code, waits out the ALU settle time, captures Z and strobes a writeback.
module alu_op_sequencer #(
    parameter int unsigned ALU_WAIT    = 1,
    parameter int unsigned MULDIV_WAIT = 4
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        start,
    input  logic [4:0]  opcode,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic [4:0]  aluControl,
    output logic [31:0] BusMuxInY,
    output logic [31:0] BusMuxOut,
    input  logic [31:0] Zlowin,
    input  logic [31:0] Zhighin,
    output logic [31:0] resultLo,
    output logic [31:0] resultHi,
    output logic        busy,
    output logic        writeEn,
    output logic        done,
    output logic        illegalOp
);

    localparam int unsigned OP_W     = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned MAX_WAIT = (ALU_WAIT > MULDIV_WAIT) ? ALU_WAIT : MULDIV_WAIT;
    localparam int unsigned CNT_W    = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOADY,
        ST_PRESENT,
        ST_WAIT,
        ST_CAPTURE,
        ST_WRITE,
        ST_ERR
    } state_t;

    state_t              r_state,    w_state_nxt;
    logic [OP_W-1:0]     r_op,       w_op_nxt;
    logic [DATA_W-1:0]   r_y,        w_y_nxt;
    logic [DATA_W-1:0]   r_b,        w_b_nxt;
    logic [CNT_W-1:0]    r_cnt,      w_cnt_nxt;
    logic [OP_W-1:0]     r_alu_ctrl, w_alu_ctrl_nxt;
    logic [DATA_W-1:0]   r_res_lo,   w_res_lo_nxt;
    logic [DATA_W-1:0]   r_res_hi,   w_res_hi_nxt;
    logic                r_busy,     w_busy_nxt;
    logic                r_write_en, w_write_en_nxt;
    logic                r_done,     w_done_nxt;
    logic                r_illegal,  w_illegal_nxt;
    logic                w_legal;
    logic                w_muldiv;
    logic [CNT_W-1:0]    w_settle_m1;

    assign w_legal  = ((opcode >= 5'd3) && (opcode <= 5'd10)) ||
                      ((opcode >= 5'd14) && (opcode <= 5'd17));
    assign w_muldiv = (r_op == 5'd14) || (r_op == 5'd15);

    // Settle cycles after aluControl is presented; the CAPTURE cycle is the last of them.
    assign w_settle_m1 = w_muldiv ? CNT_W'(MULDIV_WAIT - 1) : CNT_W'(ALU_WAIT - 1);

    // Next-state and next-register logic
    always_comb begin
        w_state_nxt    = r_state;
        w_op_nxt       = r_op;
        w_y_nxt        = r_y;
        w_b_nxt        = r_b;
        w_cnt_nxt      = r_cnt;
        w_alu_ctrl_nxt = r_alu_ctrl;
        w_res_lo_nxt   = r_res_lo;
        w_res_hi_nxt   = r_res_hi;
        w_write_en_nxt = 1'b0;
        w_done_nxt     = 1'b0;
        w_illegal_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_alu_ctrl_nxt = '0;
                if (start) begin
                    if (w_legal) begin
                        w_op_nxt    = opcode;
                        w_y_nxt     = srcA;
                        w_b_nxt     = srcB;
                        w_state_nxt = ST_LOADY;
                    end else begin
                        w_state_nxt = ST_ERR;
                    end
                end
            end
            ST_LOADY: begin
                w_state_nxt = ST_PRESENT;
            end
            ST_PRESENT: begin
                w_alu_ctrl_nxt = r_op;
                if (w_settle_m1 == '0) begin
                    w_state_nxt = ST_CAPTURE;
                end else begin
                    w_cnt_nxt   = w_settle_m1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt <= CNT_W'(1)) begin
                    w_state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                w_res_lo_nxt = Zlowin;
                w_res_hi_nxt = Zhighin;
                w_state_nxt  = ST_WRITE;
            end
            ST_WRITE: begin
                w_write_en_nxt = 1'b1;
                w_done_nxt     = 1'b1;
                w_alu_ctrl_nxt = '0;
                w_state_nxt    = ST_IDLE;
            end
            ST_ERR: begin
                w_done_nxt    = 1'b1;
                w_illegal_nxt = 1'b1;
                w_state_nxt   = ST_IDLE;
            end
            default: begin
                w_alu_ctrl_nxt = '0;
                w_state_nxt    = ST_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    // State and output registers; clear aborts immediately with no writeback
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state    <= ST_IDLE;
            r_op       <= '0;
            r_y        <= '0;
            r_b        <= '0;
            r_cnt      <= '0;
            r_alu_ctrl <= '0;
            r_res_lo   <= '0;
            r_res_hi   <= '0;
            r_busy     <= 1'b0;
            r_write_en <= 1'b0;
            r_done     <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_op       <= w_op_nxt;
            r_y        <= w_y_nxt;
            r_b        <= w_b_nxt;
            r_cnt      <= w_cnt_nxt;
            r_alu_ctrl <= w_alu_ctrl_nxt;
            r_res_lo   <= w_res_lo_nxt;
            r_res_hi   <= w_res_hi_nxt;
            r_busy     <= w_busy_nxt;
            r_write_en <= w_write_en_nxt;
            r_done     <= w_done_nxt;
            r_illegal  <= w_illegal_nxt;
        end
    end

    assign aluControl = r_alu_ctrl;
    assign BusMuxInY  = r_y;
    assign BusMuxOut  = r_b;
    assign resultLo   = r_res_lo;
    assign resultHi   = r_res_hi;
    assign busy       = r_busy;
    assign writeEn    = r_write_en;
    assign done       = r_done;
    assign illegalOp  = r_illegal;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer; the ALU is stood in for by hand-computed Z values.
module tb_alu_op_sequencer;

    logic        clk;
    logic        clear;
    logic        start;
    logic [4:0]  opcode;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic [4:0]  aluControl;
    logic [31:0] BusMuxInY;
    logic [31:0] BusMuxOut;
    logic [31:0] Zlowin;
    logic [31:0] Zhighin;
    logic [31:0] resultLo;
    logic [31:0] resultHi;
    logic        busy;
    logic        writeEn;
    logic        done;
    logic        illegalOp;

    int checks = 0;
    int errors = 0;

    alu_op_sequencer #(
        .ALU_WAIT   (1),
        .MULDIV_WAIT(4)
    ) dut (
        .clk       (clk),
        .clear     (clear),
        .start     (start),
        .opcode    (opcode),
        .srcA      (srcA),
        .srcB      (srcB),
        .aluControl(aluControl),
        .BusMuxInY (BusMuxInY),
        .BusMuxOut (BusMuxOut),
        .Zlowin    (Zlowin),
        .Zhighin   (Zhighin),
        .resultLo  (resultLo),
        .resultHi  (resultHi),
        .busy      (busy),
        .writeEn   (writeEn),
        .done      (done),
        .illegalOp (illegalOp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then settle 1 time unit before sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear = 1'b1; start = 1'b0; opcode = '0; srcA = '0; srcB = '0;
        Zlowin = '0; Zhighin = '0;
        tick();
        tick();
        checks++; if ({aluControl, busy, writeEn, done, illegalOp} !== 9'd0) begin errors++;
            $display("FAIL reset_ctrl: got alu=%0h busy=%0b we=%0b done=%0b ill=%0b expected all 0", aluControl, busy, writeEn, done, illegalOp); end
        checks++; if ({BusMuxInY, BusMuxOut, resultLo, resultHi} !== 128'd0) begin errors++;
            $display("FAIL reset_data: got Y=%0h B=%0h lo=%0h hi=%0h expected all 0", BusMuxInY, BusMuxOut, resultLo, resultHi); end
        clear = 1'b0;
        tick();
    endtask

    task automatic test_add();
        opcode = 5'd3; srcA = 32'd5; srcB = 32'd7; Zlowin = 32'd12; Zhighin = 32'd0; start = 1'b1;
        tick(); // edge 0
        start = 1'b0; srcA = 32'd99; srcB = 32'd98;
        checks++; if (BusMuxInY !== 32'd5) begin errors++; $display("FAIL add_y: got %0d expected 5", BusMuxInY); end
        checks++; if (BusMuxOut !== 32'd7) begin errors++; $display("FAIL add_b: got %0d expected 7", BusMuxOut); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL add_busy: got %0b expected 1", busy); end
        checks++; if (aluControl !== 5'd0) begin errors++; $display("FAIL add_ctrl_e0: got %0h expected 0", aluControl); end
        tick(); // edge 1
        checks++; if (aluControl !== 5'd0) begin errors++; $display("FAIL add_ctrl_e1: got %0h expected 0", aluControl); end
        checks++; if (BusMuxInY !== 32'd5) begin errors++; $display("FAIL add_y_hold: got %0d expected 5", BusMuxInY); end
        tick(); // edge 2
        checks++; if (aluControl !== 5'd3) begin errors++; $display("FAIL add_ctrl_e2: got %0h expected 3", aluControl); end
        tick(); // edge 3
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL add_done_early: got %0b expected 0", done); end
        tick(); // edge 4
        checks++; if ({done, writeEn, illegalOp} !== 3'b110) begin errors++;
            $display("FAIL add_strobes: got done=%0b we=%0b ill=%0b expected 1 1 0", done, writeEn, illegalOp); end
        checks++; if (resultLo !== 32'd12) begin errors++; $display("FAIL add_lo: got %0d expected 12", resultLo); end
        checks++; if (resultHi !== 32'd0) begin errors++; $display("FAIL add_hi: got %0h expected 0", resultHi); end
        checks++; if (aluControl !== 5'd0) begin errors++; $display("FAIL add_ctrl_e4: got %0h expected 0", aluControl); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL add_idle: got busy=%0b expected 0", busy); end
        tick(); // edge 5
        checks++; if ({done, writeEn} !== 2'b00) begin errors++; $display("FAIL add_pulse_width: got done=%0b we=%0b expected 0 0", done, writeEn); end
        checks++; if (BusMuxInY !== 32'd5) begin errors++; $display("FAIL add_y_retain: got %0d expected 5", BusMuxInY); end
    endtask

    task automatic test_sub();
        int we_cnt;
        we_cnt = 0;
        opcode = 5'd4; srcA = 32'd3; srcB = 32'd5; Zlowin = 32'hFFFF_FFFE; Zhighin = 32'hFFFF_FFFF; start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (writeEn === 1'b1) we_cnt++;
        end
        checks++; if (we_cnt !== 1) begin errors++; $display("FAIL sub_we_count: got %0d expected 1", we_cnt); end
        checks++; if (resultLo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_lo: got %0h expected fffffffe", resultLo); end
        checks++; if (resultHi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sub_hi: got %0h expected ffffffff", resultHi); end
    endtask

    task automatic test_back_to_back();
        opcode = 5'd3; srcA = 32'd5; srcB = 32'd7; Zlowin = 32'd12; Zhighin = 32'd0; start = 1'b1;
        tick(); // edge 0
        tick(); tick(); tick(); tick(); // edge 4
        checks++; if ({done, writeEn} !== 2'b11) begin errors++; $display("FAIL b2b_first_done: got done=%0b we=%0b expected 1 1", done, writeEn); end
        checks++; if (resultLo !== 32'd12) begin errors++; $display("FAIL b2b_first_lo: got %0d expected 12", resultLo); end
        checks++; if (aluControl !== 5'd0) begin errors++; $display("FAIL b2b_ctrl_drop: got %0h expected 0", aluControl); end
        srcA = 32'd1; srcB = 32'd1; Zlowin = 32'd2;
        tick(); // edge 5
        start = 1'b0;
        checks++; if (BusMuxInY !== 32'd1 || busy !== 1'b1) begin errors++;
            $display("FAIL b2b_accept: got Y=%0d busy=%0b expected 1 1", BusMuxInY, busy); end
        checks++; if (aluControl !== 5'd0) begin errors++; $display("FAIL b2b_ctrl_e5: got %0h expected 0", aluControl); end
        tick(); tick(); // edge 7
        checks++; if (aluControl !== 5'd3) begin errors++; $display("FAIL b2b_ctrl_e7: got %0h expected 3", aluControl); end
        tick(); tick(); // edge 9
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_second_done: got %0b expected 1", done); end
        checks++; if (resultLo !== 32'd2) begin errors++; $display("FAIL b2b_second_lo: got %0d expected 2", resultLo); end
        tick();
    endtask

    task automatic test_div();
        opcode = 5'd15; srcA = 32'd100; srcB = 32'd7; Zlowin = 32'd14; Zhighin = 32'd2; start = 1'b1;
        tick(); // edge 0
        start = 1'b0;
        tick(); // edge 1
        for (int e = 2; e <= 6; e++) begin
            tick();
            checks++; if (aluControl !== 5'd15) begin errors++; $display("FAIL div_ctrl_hold: edge %0d got %0h expected f", e, aluControl); end
        end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL div_done_early: got %0b expected 0", done); end
        tick(); // edge 7
        checks++; if ({done, writeEn} !== 2'b11) begin errors++; $display("FAIL div_done: got done=%0b we=%0b expected 1 1", done, writeEn); end
        checks++; if (resultLo !== 32'd14 || resultHi !== 32'd2) begin errors++;
            $display("FAIL div_result: got lo=%0d hi=%0d expected 14 2", resultLo, resultHi); end
        tick();
    endtask

    task automatic test_illegal();
        opcode = 5'd11; srcA = 32'd9; srcB = 32'd9; Zlowin = 32'd55; Zhighin = 32'd55; start = 1'b1;
        tick(); // edge 0
        start = 1'b0;
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL ill_e0: got busy=%0b done=%0b expected 1 0", busy, done); end
        tick(); // edge 1
        checks++; if ({done, illegalOp, writeEn} !== 3'b110) begin errors++;
            $display("FAIL ill_strobes: got done=%0b ill=%0b we=%0b expected 1 1 0", done, illegalOp, writeEn); end
        checks++; if (aluControl !== 5'd0) begin errors++; $display("FAIL ill_ctrl: got %0h expected 0", aluControl); end
        checks++; if (resultLo !== 32'd14 || resultHi !== 32'd2) begin errors++;
            $display("FAIL ill_result_keep: got lo=%0d hi=%0d expected 14 2", resultLo, resultHi); end
        tick(); // edge 2
        checks++; if ({done, illegalOp} !== 2'b00) begin errors++; $display("FAIL ill_pulse_width: got done=%0b ill=%0b expected 0 0", done, illegalOp); end
        opcode = 5'd0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++; if (illegalOp !== 1'b1) begin errors++; $display("FAIL ill_zero_op: got %0b expected 1", illegalOp); end
        tick();
    endtask

    task automatic test_abort();
        int done_cnt;
        int we_cnt;
        done_cnt = 0;
        we_cnt = 0;
        opcode = 5'd15; srcA = 32'd100; srcB = 32'd7; Zlowin = 32'd14; Zhighin = 32'd2; start = 1'b1;
        tick(); // edge 0
        start = 1'b0;
        tick(); tick(); // edge 2, now waiting
        opcode = 5'd3; srcA = 32'd77; start = 1'b1;
        tick(); // edge 3: must be ignored
        start = 1'b0;
        for (int e = 4; e <= 12; e++) begin
            tick();
            if (done === 1'b1) done_cnt++;
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL abort_ignore_start: got %0d done pulses expected 1", done_cnt); end
        checks++; if (BusMuxInY !== 32'd100) begin errors++; $display("FAIL abort_y_unchanged: got %0d expected 100", BusMuxInY); end

        opcode = 5'd15; srcA = 32'd100; srcB = 32'd7; start = 1'b1;
        tick(); // edge 0
        start = 1'b0;
        tick(); tick(); tick(); // edge 3, mid-wait
        clear = 1'b1;
        #2;
        checks++; if ({aluControl, busy, writeEn, done, illegalOp} !== 9'd0) begin errors++;
            $display("FAIL abort_clear_ctrl: got alu=%0h busy=%0b we=%0b done=%0b ill=%0b expected all 0", aluControl, busy, writeEn, done, illegalOp); end
        checks++; if ({BusMuxInY, BusMuxOut, resultLo, resultHi} !== 128'd0) begin errors++;
            $display("FAIL abort_clear_data: got Y=%0h B=%0h lo=%0h hi=%0h expected all 0", BusMuxInY, BusMuxOut, resultLo, resultHi); end
        tick();
        clear = 1'b0;
        for (int e = 0; e < 8; e++) begin
            tick();
            if (writeEn === 1'b1) we_cnt++;
        end
        checks++; if (we_cnt !== 0) begin errors++; $display("FAIL abort_no_writeback: got %0d pulses expected 0", we_cnt); end

        opcode = 5'd3; srcA = 32'd2; srcB = 32'd3; Zlowin = 32'd5; Zhighin = 32'd0; start = 1'b1;
        tick(); // edge 0
        start = 1'b0;
        tick(); tick(); tick(); tick(); // edge 4
        checks++; if ({done, writeEn} !== 2'b11 || resultLo !== 32'd5) begin errors++;
            $display("FAIL abort_fresh_op: got done=%0b we=%0b lo=%0d expected 1 1 5", done, writeEn, resultLo); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_div();
        test_illegal();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
